// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
// The loader states and the default memory depth live here.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 37;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_LO  = 3'd1,
    ST_HDR_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CKSUM   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

endpackage

// File: rtl/imem_loader_wr_reg.sv
// Write-port register stage: registers wr_en, wr_addr and wr_data one cycle after
// the word is assembled, and counts the words written in the current load.
module imem_loader_wr_reg
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_req,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [15:0]       wr_word,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [CNT_W-1:0]  words_loaded
);

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  words_q, words_d;

  // Address and data hold between writes; only the strobe is a pulse.
  always_comb begin
    wr_en_d   = wr_req;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;
    if (clear) begin
      words_d = '0;
    end else if (wr_req) begin
      wr_addr_d = ADDR_W'(wr_idx);
      wr_data_d = wr_word;
      words_d   = words_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit little-endian header count, then
// N words written to sequential addresses. Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       lo_q, lo_d;
  logic [CNT_W-1:0] hdr_n;
  logic             accept;
  logic             start_ok;
  logic             wr_req;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
  localparam state_e ST_AFTER_DATA = ST_CKSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  assign accept = byte_valid && byte_ready;
  assign hdr_n  = CNT_W'({byte_in, n_q[7:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    start_ok = 1'b0;
    wr_req   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cksum_d  = cksum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_HDR_LO;
          n_d      = '0;
          idx_d    = '0;
          lo_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          cksum_d  = '0;
`endif
        end
      end
      ST_HDR_LO: if (accept) begin
        n_d     = CNT_W'(byte_in);
        state_d = ST_HDR_HI;
      end
      ST_HDR_HI: if (accept) begin
        n_d = hdr_n;
        if (hdr_n > CNT_W'(DEPTH))  state_d = ST_ERR;
        else if (hdr_n == '0)       state_d = ST_AFTER_DATA;
        else                        state_d = ST_DATA_LO;
      end
      ST_DATA_LO: if (accept) begin
        lo_d    = byte_in;
        state_d = ST_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cksum_d = cksum_q ^ byte_in;
`endif
      end
      ST_DATA_HI: if (accept) begin
        wr_req = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cksum_d = cksum_q ^ byte_in;
`endif
        if (idx_q == n_q - 1'b1) begin
          state_d = ST_AFTER_DATA;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DATA_LO;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CKSUM: if (accept) begin
        state_d = (byte_in == cksum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      ST_HDR_LO, ST_HDR_HI, ST_DATA_LO, ST_DATA_HI, ST_CKSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_DONE: done  = 1'b1;
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  imem_loader_wr_reg #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_wr_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start_ok),
    .wr_req       (wr_req),
    .wr_idx       (idx_q),
    .wr_word      ({byte_in, lo_q}),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .words_loaded (words_loaded)
  );

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Drives the instruction memory write port with sequential word addresses starting at 0.
- Sits between the boot/host byte source and the memory array. The processor holds off fetch until done is set.

Parameters:
- DEPTH, 37, number of 16-bit words in instruction memory; maximum legal load length.
- ADDR_W, 32, width of wr_addr; matches the fetch address width.
- CNT_W, 16, width of the header word count and the internal counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  16  instruction word, {hi byte, lo byte}.
- busy  out  1  load in progress.
- done  out  1  load completed successfully; held.
- error  out  1  load aborted; held.
- words_loaded  out  CNT_W  words written so far in the current load.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal counters and byte latch cleared.
- A byte is accepted only on a clock edge where byte_valid && byte_ready.
- byte_ready is a pure function of state: 1 in HDR_LO, HDR_HI, DATA_LO, DATA_HI and CKSUM; 0 otherwise.
- States and transitions:
  - IDLE/DONE/ERR: on start -> HDR_LO. done, error and words_loaded are cleared on that edge.
  - HDR_LO: accept byte -> N[7:0]; go to HDR_HI.
  - HDR_HI: accept byte -> N[15:8]. Next state:
    - N > DEPTH -> ERR.
    - N == 0 -> DONE (or CKSUM when CHECKSUM_EN is defined).
    - otherwise -> DATA_LO.
  - DATA_LO: accept byte into lo latch -> DATA_HI.
  - DATA_HI: accept byte and register the write.
    - Next cycle: wr_en=1, wr_addr=idx, wr_data={byte,lo}; words_loaded increments.
    - Last word (idx == N-1) -> DONE (or CKSUM); otherwise idx++ and -> DATA_LO.
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0.
- Write timing:
  - wr_en is registered: it asserts exactly one cycle after the DATA_HI accept and deasserts the following cycle.
  - wr_addr and wr_data hold their last values while wr_en=0.
- busy=1 in every state except IDLE, DONE and ERR.
- start is ignored while busy.
- byte_valid outside the ready states is ignored; no bytes are consumed.
- Stalls: byte_valid low for any number of cycles holds the state; no timeout.
- Address arithmetic: idx is CNT_W wide and zero-extended to ADDR_W. idx never exceeds DEPTH-1, so it never wraps.
- Reset mid-load: immediate return to IDLE; no further wr_en. Partially written memory contents are left as they are.
- Simultaneous start and byte_valid in IDLE: start is taken and the byte is not consumed, because byte_ready=0 in IDLE.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or the header, when N=0), the CKSUM state accepts one byte.
  - It is compared against the XOR of all data bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - The memory writes already performed remain.
- Undefined: the CKSUM state, the XOR accumulator and the compare logic are absent. DATA_HI on the last word goes directly to DONE.

Decomposition:
- Shared package: state encoding enum (IDLE, HDR_LO, HDR_HI, DATA_LO, DATA_HI, CKSUM, DONE, ERR) and the default IMEM_DEPTH=37, shared with the instruction memory.
- One natural sub-module, imem_loader_wr_reg: registers wr_en, wr_addr and wr_data, and increments words_loaded. Everything else is the FSM in the top.

Test Plan:
- Reset: assert rst_n=0 mid-DATA_HI -> byte_ready=0, wr_en=0, busy=0, state IDLE on the next edge with no clock needed.
- Basic load: start; bytes 02 00 34 12 CD AB sent back-to-back -> wr_en pulses at addr 0 data 16'h1234 and addr 1 data 16'hABCD, then done=1, words_loaded=2.
- Overflow: header N=38 (26 00) -> error=1 after HDR_HI, no wr_en ever, byte_ready=0.
- Full depth: N=37 -> 37 writes, last at wr_addr=36, then done=1.
- Backpressure and ignored start: byte_valid toggled 1/0 every cycle; start pulsed mid-load -> same writes as the basic load, start ignored.
- Checksum (IMEM_LOADER_CHECKSUM_EN): N=1, data 34 12, checksum 26 -> done=1. Same load with checksum 27 -> error=1, one write of 16'h1234 still observed.
